instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage placed directly downstream of the program counter `PC`. It reads the PC's `Output`, issues a word read to instruction memory over a req/ack handshake, and presents the fetched instruction to decode through a valid/ready handshake. It drives the PC's `inclement` and `load` inputs, advancing sequentially or redirecting on a branch. The PC is word-addressed (+1 per instruction), so `mem_addr` equals the PC value.

## Interface
- `DATA_WIDTH`, 32: instruction/memory data width.
- `ADDR_WIDTH`, 32: PC/memory address width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_value`  in  ADDR_WIDTH  current PC (PC `Output`).
- `pc_inclement`  out  1  one-cycle pulse to PC `inclement`.
- `pc_load`  out  1  one-cycle pulse to PC `load`.
- `pc_load_value`  out  ADDR_WIDTH  to PC `Input`; valid while `pc_load`=1.
- `redirect`  in  1  branch/jump taken, single-cycle pulse.
- `redirect_target`  in  ADDR_WIDTH  new PC; sampled when `redirect`=1.
- `mem_req`  out  1  memory read request, held until `mem_ack`.
- `mem_addr`  out  ADDR_WIDTH  read address (= `pc_value` during a request).
- `mem_ack`  in  1  read complete; `mem_rdata` valid this cycle.
- `mem_rdata`  in  DATA_WIDTH  read data.
- `instr_valid`  out  1  `instr`/`instr_pc` valid for decode.
- `instr_ready`  in  1  decode accepts the instruction.
- `instr`  out  DATA_WIDTH  fetched instruction.
- `instr_pc`  out  ADDR_WIDTH  address of `instr`.

## Operation
- FSM states: IDLE, FETCH, HOLD, DRAIN, REDIRECT. All outputs are Moore, decoded from the state and registers.
- Reset (async, immediate) sets: state IDLE; `instr`, `instr_pc`, and the pending-target register to 0; all outputs 0.
- Any outstanding memory request is abandoned on reset; memory must tolerate `mem_req` dropping without an ack.
- IDLE → FETCH next cycle. If `redirect`=1, IDLE → REDIRECT instead.
- FETCH:
  - `mem_req`=1 and `mem_addr`=`pc_value`. The PC is not modified in FETCH, so the address is stable.
  - On `mem_ack`: capture `instr`←`mem_rdata` and `instr_pc`←`pc_value`, then go to HOLD.
  - `mem_ack` is allowed in the same cycle `mem_req` rises.
- HOLD:
  - `instr_valid`=1.
  - `pc_inclement`=1 in the first HOLD cycle only.
  - On `instr_ready`, go to FETCH. Otherwise stay, with `instr` and `instr_pc` stable.
- Redirect handling:
  - `redirect` latches `redirect_target` into the pending register in any state.
  - FETCH without `mem_ack` → DRAIN. `mem_req` stays 1 at the same address until ack; the returned data is discarded.
  - FETCH with `mem_ack` in the same cycle: discard the data, no HOLD, go to REDIRECT.
  - HOLD → REDIRECT. If `instr_ready`=1 in the same cycle, the handshake still completes (the instruction counts as consumed).
  - In REDIRECT: latch the newest target and stay one more cycle.
- DRAIN → REDIRECT on `mem_ack`. Nothing is captured and no `instr_valid` is raised.
- REDIRECT: `pc_load`=1 and `pc_load_value`=pending target for one cycle, then FETCH.
- `pc_load` and `pc_inclement` are never both 1, since they are decoded from distinct states.
- If the first HOLD cycle is redirected, that cycle's `pc_inclement` still takes effect; the subsequent load overrides it.

## Timing
- Let FETCH be entered at cycle N and `mem_ack` arrive at cycle N+k (k≥0). Then `instr_valid`=1 from cycle N+k+1.
- `pc_inclement` pulses in cycle N+k+1. The PC holds the incremented value from N+k+2.
- With `instr_ready`=1 and k=0, throughput is one instruction per 2 cycles.
- Redirect raised in HOLD at cycle M:
  - `pc_load` in M+1.
  - FETCH in M+2, with `mem_addr`=target.
- After reset release: IDLE for 1 cycle, then FETCH with `mem_addr`=0.
- `instr_valid` never drops without a handshake, except on redirect or reset.

## Test plan
- Reset: assert `reset` mid-FETCH → `mem_req`, `instr_valid`, `pc_*` drop to 0 immediately. Release → `mem_req`=1, `mem_addr`=0 one cycle later.
- Sequential fetch: zero-wait memory with mem[0]=0x00000013, mem[1]=0x00500093, `instr_ready`=1.
  - Expect `instr`=0x00000013 with `instr_pc`=0, then 0x00500093 with `instr_pc`=1.
  - Exactly one `pc_inclement` pulse per instruction; PC reaches 2.
- Backpressure: hold `instr_ready`=0 for 5 cycles → `instr_valid` stays 1, `instr` is stable, exactly one `pc_inclement`, `mem_req`=0 throughout.
- Wait states: `mem_ack` delayed 3 cycles → `mem_req`=1 and `mem_addr` stable for 4 cycles. `instr_valid` rises the cycle after ack.
- Redirect with a request outstanding: `redirect` with target 47 in FETCH, ack delayed 2 cycles.
  - `mem_req` held to ack, data discarded, no `instr_valid`.
  - `pc_load`=1 with `pc_load_value`=47, then `mem_addr`=47 and `instr_pc`=47.
- Redirect in the first HOLD cycle with `instr_ready`=1: `pc_inclement` pulse plus accept, then a `pc_load` pulse with 47. `pc_load` and `pc_inclement` are never high together.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetches pc_value over mem req/ack, hands instr to decode via valid/ready, drives PC inclement/load for sequential flow and redirects
module instruction_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_value,
  output logic                  pc_inclement,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_load_value,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
);
  typedef enum logic [2:0] {IDLE, FETCH, HOLD, DRAIN, REDIRECT} state_t;
  state_t state, next_state;
  logic first_hold;
  logic [ADDR_WIDTH-1:0] pending;
  logic capture;
  assign capture = state == FETCH && mem_ack && !redirect;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     next_state = redirect ? REDIRECT : FETCH;
      FETCH:    next_state = redirect ? (mem_ack ? REDIRECT : DRAIN) : (mem_ack ? HOLD : FETCH);
      HOLD:     next_state = redirect ? REDIRECT : (instr_ready ? FETCH : HOLD);
      DRAIN:    next_state = mem_ack ? REDIRECT : DRAIN;
      REDIRECT: next_state = redirect ? REDIRECT : FETCH;
      default:  next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      first_hold <= 1'b0;
      pending    <= '0;
      instr      <= '0;
      instr_pc   <= '0;
    end else begin
      first_hold <= capture;
      if (redirect) pending <= redirect_target;
      if (capture) begin
        instr    <= mem_rdata;
        instr_pc <= pc_value;
      end
    end
  always_comb begin
    mem_req       = state == FETCH || state == DRAIN;
    mem_addr      = mem_req ? pc_value : '0;
    instr_valid   = state == HOLD;
    pc_inclement  = state == HOLD && first_hold;
    pc_load       = state == REDIRECT;
    pc_load_value = pc_load ? pending : '0;
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed steps with a PC/memory model and an instruction scoreboard
module tb_instruction_fetch;
  logic        clk, reset;
  logic [31:0] pc_value, pc_load_value, redirect_target, mem_addr, mem_rdata, instr, instr_pc;
  logic        pc_inclement, pc_load, redirect, mem_req, mem_ack, instr_valid, instr_ready;
  typedef struct packed {logic [31:0] i; logic [31:0] p;} exp_t;
  exp_t        q[$];
  logic [31:0] mem [64];
  int          wait_n, cnt, inc_cnt, n_assert, n_fail;
  instruction_fetch dut (
    .clk(clk), .reset(reset), .pc_value(pc_value), .pc_inclement(pc_inclement),
    .pc_load(pc_load), .pc_load_value(pc_load_value), .redirect(redirect),
    .redirect_target(redirect_target), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk or posedge reset)
    if (reset) pc_value <= '0;
    else if (pc_load) pc_value <= pc_load_value;
    else if (pc_inclement) pc_value <= pc_value + 1;
  always @(posedge clk or posedge reset)
    if (reset) cnt <= 0;
    else if (!mem_req || mem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  assign mem_ack   = mem_req && cnt >= wait_n;
  assign mem_rdata = mem[mem_addr[5:0]];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic half();
    @(negedge clk);
    chk("load_inc_exclusive", {31'd0, pc_load & pc_inclement}, 0);
    inc_cnt += int'(pc_inclement);
    if (instr_valid && instr_ready) begin
      if (q.size() == 0) chk("unexpected_instr", 1, 0);
      else begin
        exp_t e = q.pop_front();
        chk("sb_instr", instr, e.i);
        chk("sb_instr_pc", instr_pc, e.p);
      end
    end
  endtask
  initial begin
    n_assert = 0; n_fail = 0; inc_cnt = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0050_0093;
    reset = 1; redirect = 0; redirect_target = 0; instr_ready = 0; wait_n = 100;
    tick(); tick();
    reset = 0;
    half(); chk("idle_no_req", {31'd0, mem_req}, 0); tick();
    half(); chk("fetch_req", {31'd0, mem_req}, 1); chk("fetch_addr", mem_addr, 0);
    #1 reset = 1;
    #1 chk("rst_req", {31'd0, mem_req}, 0); chk("rst_valid", {31'd0, instr_valid}, 0);
    chk("rst_inc", {31'd0, pc_inclement}, 0); chk("rst_load", {31'd0, pc_load}, 0);
    chk("rst_instr", instr, 0);
    tick(); tick();
    wait_n = 0; instr_ready = 1;
    q.push_back('{32'h0000_0013, 32'd0});
    q.push_back('{32'h0050_0093, 32'd1});
    reset = 0;
    half(); chk("post_rst_idle", {31'd0, mem_req}, 0); tick();
    half(); chk("post_rst_req", {31'd0, mem_req}, 1); chk("post_rst_addr", mem_addr, 0); tick();
    half(); chk("hold0_valid", {31'd0, instr_valid}, 1); chk("hold0_inc", {31'd0, pc_inclement}, 1); tick();
    half(); chk("fetch1_addr", mem_addr, 1); tick();
    instr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      half();
      chk("bp_valid", {31'd0, instr_valid}, 1);
      chk("bp_instr", instr, 32'h0050_0093);
      chk("bp_req", {31'd0, mem_req}, 0);
      tick();
    end
    chk("bp_inc_count", inc_cnt, 2);
    chk("pc_reaches_2", pc_value, 2);
    instr_ready = 1; wait_n = 3;
    half(); tick();
    instr_ready = 0;
    q.push_back('{32'hA000_0002, 32'd2});
    for (int i = 0; i < 4; i++) begin
      half();
      chk("ws_req", {31'd0, mem_req}, 1);
      chk("ws_addr", mem_addr, 2);
      chk("ws_no_valid", {31'd0, instr_valid}, 0);
      tick();
    end
    instr_ready = 1; wait_n = 2;
    half(); chk("ws_valid_after_ack", {31'd0, instr_valid}, 1); tick();
    instr_ready = 0; redirect = 1; redirect_target = 47;
    half(); chk("rd_fetch_req", {31'd0, mem_req}, 1); chk("rd_fetch_addr", mem_addr, 3); tick();
    redirect = 0; redirect_target = 99;
    for (int i = 0; i < 2; i++) begin
      half();
      chk("drain_req", {31'd0, mem_req}, 1);
      chk("drain_addr", mem_addr, 3);
      chk("drain_no_valid", {31'd0, instr_valid}, 0);
      chk("drain_no_load", {31'd0, pc_load}, 0);
      tick();
    end
    wait_n = 0;
    q.push_back('{32'hA000_002F, 32'd47});
    half();
    chk("rd_load", {31'd0, pc_load}, 1); chk("rd_load_value", pc_load_value, 47);
    chk("rd_no_req", {31'd0, mem_req}, 0); chk("rd_no_valid", {31'd0, instr_valid}, 0);
    tick();
    half(); chk("rd_target_req", {31'd0, mem_req}, 1); chk("rd_target_addr", mem_addr, 47); tick();
    instr_ready = 1; redirect = 1; redirect_target = 47;
    half(); chk("hr_instr_pc", instr_pc, 47); chk("hr_inc", {31'd0, pc_inclement}, 1); tick();
    redirect = 0; redirect_target = 5;
    q.push_back('{32'hA000_002F, 32'd47});
    half();
    chk("hr_load", {31'd0, pc_load}, 1); chk("hr_load_value", pc_load_value, 47);
    chk("hr_no_inc", {31'd0, pc_inclement}, 0); chk("hr_no_valid", {31'd0, instr_valid}, 0);
    tick();
    half(); chk("hr_fetch_addr", mem_addr, 47); tick();
    half(); chk("hr_valid", {31'd0, instr_valid}, 1); tick();
    instr_ready = 0;
    half(); tick();
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
